mem_wr_monitor: RTL and testbench

- Sink end of the manta_style data-memory write port: consumes `mem_wr_en` / `mem_wr_dest` / `mem_wr_data` exactly as the core drives them.
- Counts writes and logs MMIO-region writes into a show-ahead FIFO for a debug reader.
- Detects the end-of-test handshake (write of 16'hd074 to 16'hd074), then runs a fixed drain period and raises `done`.
- Replaces bench-side polling of the write port; synthesizable so the same end-of-test logic exists on hardware.

---
 rtl/manta_style_pkg.sv | 15 +
 rtl/mem_wr_log_fifo.sv | 75 +++++++
 rtl/mem_wr_monitor.sv | 163 ++++++++++++++++
 tb/tb_mem_wr_monitor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/manta_style_pkg.sv
// Shared constants and state encoding for the manta_style write-port monitor.
package manta_style_pkg;

  localparam int          WORD_W        = 16;
  localparam logic [15:0] EOT_ADDR      = 16'hd074;
  localparam logic [15:0] EOT_DATA      = 16'hd074;
  localparam logic [15:0] MMIO_BASE_DEF = 16'hd000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } mon_state_t;

endpackage

// File: rtl/mem_wr_log_fifo.sv
// Show-ahead synchronous FIFO: the head entry is held in a register, so a push
// into an empty FIFO is visible on head_data the cycle after it lands.
module mem_wr_log_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;
  logic             w_bypass;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [CNT_W-1:0] w_count_next;
  logic [WIDTH-1:0] w_head_next;

  assign w_full        = (r_count == CNT_W'(DEPTH));
  assign w_do_pop      = pop && r_valid;
  assign w_do_push     = push && (!w_full || w_do_pop);
  assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_do_pop);
  assign w_count_next  = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);

  // The incoming entry becomes the new head when nothing older survives this cycle.
  assign w_bypass    = w_do_push && ((r_count == '0) ||
                                     ((r_count == CNT_W'(1)) && w_do_pop));
  assign w_head_next = w_bypass ? push_data : r_mem[w_rd_ptr_next];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      r_head   <= w_head_next;
    end
  end

  assign head_data = r_head;
  assign valid     = r_valid;
  assign full      = w_full;
  assign count     = r_count;

endmodule

// File: rtl/mem_wr_monitor.sv
// Write-port sink: counts writes, logs MMIO writes, detects end-of-test and drains.
// Optional watchdog timeout is compiled in with MEM_WR_MONITOR_WATCHDOG_EN.
module mem_wr_monitor
  import manta_style_pkg::*;
#(
  parameter int                          WORD_W          = manta_style_pkg::WORD_W,
  parameter logic [WORD_W-1:0]           MMIO_BASE       = WORD_W'(MMIO_BASE_DEF),
  parameter int                          LOG_DEPTH       = 8,
  parameter int                          DRAIN_CYCLES    = 5,
  parameter int                          WATCHDOG_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_wr_en,
  input  logic [WORD_W-1:0]            mem_wr_dest,
  input  logic [WORD_W-1:0]            mem_wr_data,
  input  logic                         log_rd_en,
  output logic                         log_rd_valid,
  output logic [WORD_W-1:0]            log_rd_dest,
  output logic [WORD_W-1:0]            log_rd_data,
  output logic [$clog2(LOG_DEPTH):0]   log_count,
  output logic                         log_overflow,
  output logic [15:0]                  wr_count,
  output logic [31:0]                  cycle_count,
  output logic                         eot,
  output logic                         done,
  output logic                         timeout
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

  mon_state_t         r_state;
  mon_state_t         w_state_next;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_cnt_next;
  logic [15:0]        r_wr_count;
  logic [31:0]        r_cycle_count;
  logic               r_eot;
  logic               r_done;
  logic               r_overflow;

  logic               w_accept;
  logic               w_is_eot;
  logic               w_log_push;
  logic               w_log_pop;
  logic               w_fifo_full;
  logic               w_wd_fire;
  logic [2*WORD_W-1:0] w_head;

  assign w_accept   = mem_wr_en && (r_state != DONE);
  assign w_is_eot   = mem_wr_en && (r_state == RUN) &&
                      (mem_wr_dest == WORD_W'(EOT_ADDR)) &&
                      (mem_wr_data == WORD_W'(EOT_DATA));
  // The handshake write itself is counted but kept out of the log.
  assign w_log_push = w_accept && (mem_wr_dest >= MMIO_BASE) && !w_is_eot;
  assign w_log_pop  = log_rd_en && log_rd_valid;

  always_comb begin
    w_state_next     = r_state;
    w_drain_cnt_next = r_drain_cnt;
    w_wd_fire        = 1'b0;
    case (r_state)
      RUN: begin
        if (w_is_eot) begin
          w_state_next     = DRAIN;
          w_drain_cnt_next = DRAIN_W'(DRAIN_CYCLES - 1);
        end
`ifdef MEM_WR_MONITOR_WATCHDOG_EN
        else if (r_cycle_count == 32'(WATCHDOG_CYCLES - 1)) begin
          w_state_next = DONE;
          w_wd_fire    = 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_next = DONE;
        end else begin
          w_drain_cnt_next = r_drain_cnt - DRAIN_W'(1);
        end
      end
      DONE: begin
        w_state_next = DONE;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_drain_cnt   <= '0;
      r_wr_count    <= '0;
      r_cycle_count <= '0;
      r_eot         <= 1'b0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_cnt_next;
      if (w_accept) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      if ((r_state != DONE) && (r_cycle_count != '1)) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (w_is_eot) begin
        r_eot <= 1'b1;
      end
      if (w_state_next == DONE) begin
        r_done <= 1'b1;
      end
      if (w_log_push && w_fifo_full && !w_log_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef MEM_WR_MONITOR_WATCHDOG_EN
  logic r_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_wd_fire) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  // Watchdog absent: the limit parameter is only folded into a dead signal.
  logic w_unused_wd;
  assign w_unused_wd = ^{32'(WATCHDOG_CYCLES), w_wd_fire};
  assign timeout     = 1'b0;
`endif

  mem_wr_log_fifo #(
    .WIDTH (2 * WORD_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_log_push),
    .push_data ({mem_wr_dest, mem_wr_data}),
    .pop       (log_rd_en),
    .head_data (w_head),
    .valid     (log_rd_valid),
    .full      (w_fifo_full),
    .count     (log_count)
  );

  assign log_rd_dest  = w_head[2*WORD_W-1:WORD_W];
  assign log_rd_data  = w_head[WORD_W-1:0];
  assign log_overflow = r_overflow;
  assign wr_count     = r_wr_count;
  assign cycle_count  = r_cycle_count;
  assign eot          = r_eot;
  assign done         = r_done;

endmodule

// File: tb/tb_mem_wr_monitor.sv
// Randomised scoreboard bench for mem_wr_monitor with a cycle-level reference model.
module tb_mem_wr_monitor;

  localparam int DEPTH = 8;
  localparam int DRAIN = 5;
  localparam int WD    = 20;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          mem_wr_en;
  logic [15:0]   mem_wr_dest;
  logic [15:0]   mem_wr_data;
  logic          log_rd_en;
  logic          log_rd_valid;
  logic [15:0]   log_rd_dest;
  logic [15:0]   log_rd_data;
  logic [CW-1:0] log_count;
  logic          log_overflow;
  logic [15:0]   wr_count;
  logic [31:0]   cycle_count;
  logic          eot;
  logic          done;
  logic          timeout;

  mem_wr_monitor #(
    .WORD_W          (16),
    .MMIO_BASE       (16'hd000),
    .LOG_DEPTH       (DEPTH),
    .DRAIN_CYCLES    (DRAIN),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_dest  (mem_wr_dest),
    .mem_wr_data  (mem_wr_data),
    .log_rd_en    (log_rd_en),
    .log_rd_valid (log_rd_valid),
    .log_rd_dest  (log_rd_dest),
    .log_rd_data  (log_rd_data),
    .log_count    (log_count),
    .log_overflow (log_overflow),
    .wr_count     (wr_count),
    .cycle_count  (cycle_count),
    .eot          (eot),
    .done         (done),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dest;
    logic [15:0] data;
  } ent_t;

  ent_t   exp_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  // Reference state, advanced once per clock edge.
  longint m_wr       = 0;
  longint m_cyc      = 0;
  bit     m_eot      = 0;
  bit     m_done     = 0;
  bit     m_to       = 0;
  bit     m_ovf      = 0;
  int     m_cnt      = 0;
  longint edge_no    = 0;
  longint eot_edge   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic check_outputs();
    chk("wr_count",     64'(wr_count),     64'(m_wr));
    chk("cycle_count",  64'(cycle_count),  64'(m_cyc));
    chk("eot",          64'(eot),          64'(m_eot));
    chk("done",         64'(done),         64'(m_done));
    chk("timeout",      64'(timeout),      64'(m_to));
    chk("log_count",    64'(log_count),    64'(m_cnt));
    chk("log_rd_valid", 64'(log_rd_valid), 64'(m_cnt > 0));
    chk("log_overflow", 64'(log_overflow), 64'(m_ovf));
  endtask

  // Apply the monitor's rules for one edge with the given inputs.
  task automatic model_edge(input bit r, input bit we, input logic [15:0] d,
                            input logic [15:0] dat, input bit re);
    bit   pop;
    bit   eot_now;
    bit   wd_now;
    ent_t e;
    if (r) begin
      m_wr = 0; m_cyc = 0; m_eot = 0; m_done = 0; m_to = 0; m_ovf = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      pop     = re && (m_cnt > 0);
      eot_now = 0;
      wd_now  = 0;
      if (!m_done) begin
        eot_now = we && !m_eot && (d == 16'hd074) && (dat == 16'hd074);
`ifdef MEM_WR_MONITOR_WATCHDOG_EN
        wd_now = !m_eot && !eot_now && (m_cyc == longint'(WD - 1));
`endif
        if (m_cyc < 64'hffffffff) m_cyc++;
        if (we) begin
          m_wr = (m_wr + 1) % 65536;
          if (d >= 16'hd000 && !eot_now) begin
            if (m_cnt < DEPTH || pop) begin
              e.dest = d;
              e.data = dat;
              exp_q.push_back(e);
              m_cnt++;
            end else begin
              m_ovf = 1;
            end
          end
        end
        if (eot_now) begin
          m_eot    = 1;
          eot_edge = edge_no;
        end else if (m_eot && edge_no == eot_edge + DRAIN) begin
          m_done = 1;
        end
        if (wd_now) begin
          m_done = 1;
          m_to   = 1;
        end
      end
      if (pop) m_cnt--;
    end
    edge_no++;
  endtask

  task automatic drive(input bit r, input bit we, input logic [15:0] d,
                       input logic [15:0] dat, input bit re);
    @(negedge clk);
    check_outputs();
    #1;
    rst         = r;
    mem_wr_en   = we;
    mem_wr_dest = d;
    mem_wr_data = dat;
    log_rd_en   = re;
    model_edge(r, we, d, dat, re);
  endtask

  task automatic idle(input int n, input bit re);
    for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 16'h0, re);
  endtask

  task automatic do_reset();
    drive(1, 0, 16'h0, 16'h0, 0);
  endtask

  // Scoreboard monitor: whenever a pop is about to be taken, compare the head.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (log_rd_en === 1'b1 && log_rd_valid === 1'b1 && rst === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL log_pop: got %h/%h expected no entry", log_rd_dest, log_rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("log_rd_dest", 64'(log_rd_dest), 64'(e.dest));
          chk("log_rd_data", 64'(log_rd_data), 64'(e.data));
          $display("[TB] log pop dest=%h data=%h", log_rd_dest, log_rd_data);
        end
      end
    end
  end

  initial begin
    int          sel;
    bit          we;
    bit          re;
    logic [15:0] d;
    logic [15:0] dat;

    rst = 1'b1; mem_wr_en = 1'b0; mem_wr_dest = '0; mem_wr_data = '0; log_rd_en = 1'b0;
    do_reset();
    do_reset();

    // Plain and MMIO write, then pop the single log entry.
    drive(0, 1, 16'h0010, 16'h1111, 0);
    drive(0, 1, 16'hd002, 16'hbeef, 0);
    idle(1, 0);
    idle(1, 1);
    idle(1, 0);

    // Near-miss handshakes: address match only, data match only.
    drive(0, 1, 16'hd074, 16'h0000, 0);
    drive(0, 1, 16'h0074, 16'hd074, 0);
    idle(2, 1);
    do_reset();

    // Overfill, then push+pop while full, then drain.
    for (int i = 0; i < 9; i++) drive(0, 1, 16'hd100 + 16'(i), 16'($urandom), 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 16'hd200 + 16'(i), 16'($urandom), 1);
    idle(10, 1);
    do_reset();

    // End of test, repeated handshake in drain, writes ignored after done.
    drive(0, 1, 16'hd074, 16'hd074, 0);
    drive(0, 1, 16'hd074, 16'hd074, 0);
    drive(0, 1, 16'hd300, 16'h1234, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 16'hd400 + 16'(i), 16'h5555, 0);
    idle(4, 1);

    // Reset in the middle of draining, then a full second sequence.
    do_reset();
    drive(0, 1, 16'hd074, 16'hd074, 0);
    idle(2, 0);
    do_reset();
    drive(0, 1, 16'hd074, 16'hd074, 0);
    idle(8, 0);

    // Long idle run: watchdog territory when compiled in.
    do_reset();
    idle(25, 0);

    // Randomised segments.
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        we  = ($urandom_range(0, 1) == 1);
        sel = $urandom_range(0, 19);
        if (sel == 0) begin
          d = 16'hd074; dat = 16'hd074;
        end else if (sel < 9) begin
          d = 16'hd000 + 16'($urandom_range(0, 255)); dat = 16'($urandom);
        end else if (sel == 9) begin
          d = 16'hd074; dat = 16'($urandom);
        end else begin
          d = 16'($urandom); dat = 16'($urandom);
        end
        re = ($urandom_range(0, 3) == 0);
        drive(0, we, d, dat, re);
      end
      idle(12, 1);
    end

    idle(1, 0);
    @(negedge clk);
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
